// File: rtl/conv_job_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the Sobel convolution job scheduler:
//   - FSM state encoding
//   - host register byte offsets
//   - CTRL / STATUS bit positions
// ---------------------------------------------------------------------------
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT    = 3'd2,
      S_RELEASE = 3'd3,
      S_NEXT    = 3'd4,
      S_KILL    = 3'd5
   } state_t;

   // Register byte offsets (word aligned)
   localparam logic [7:0] REG_CTRL        = 8'h00;
   localparam logic [7:0] REG_STATUS      = 8'h04;
   localparam logic [7:0] REG_NUM_FRAMES  = 8'h08;
   localparam logic [7:0] REG_FRAMES_DONE = 8'h0C;
   localparam logic [7:0] REG_LAST_CYCLES = 8'h10;
   localparam logic [7:0] REG_TIMEOUT     = 8'h14;

   // CTRL bits
   localparam int CTRL_GO     = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bits
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_TO   = 2;
   localparam int ST_BANK = 3;

endpackage

// File: rtl/conv_job_sched.sv
// ---------------------------------------------------------------------------
// conv_job_sched
//   Register-programmed job scheduler for the Sobel convolution core. Runs
//   NUM_FRAMES back-to-back frames through the core's level start/done
//   handshake, ping-pongs the BRAM bank per frame, records the cycle count
//   of the last frame, enforces a watchdog timeout and soft-resets the core
//   on abort or timeout.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reg_wr / reg_rd       host register write / read strobes
//   reg_addr, reg_wdata   host byte address and write data
//   reg_rdata             read data, valid one cycle after reg_rd
//   conv_start            level start to core, held until done is seen
//   conv_done             core done level
//   conv_rst_n            synchronous soft reset to core, active-low
//   bank_sel              BRAM bank used by the current frame
//   busy                  job in progress
//   irq                   (done_flag | timeout_flag) & irq_en
// ---------------------------------------------------------------------------
module conv_job_sched
   import conv_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int CNT_W      = 32,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic              conv_start,
   input  logic              conv_done,
   output logic              conv_rst_n,
   output logic              bank_sel,
   output logic              busy,
   output logic              irq
);

   localparam int KW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
   localparam logic [KW-1:0] KILL_LAST = KW'(RST_CYCLES - 1);

   state_t           r_state;
   logic             r_start;
   logic             r_conv_rst_n;
   logic             r_bank;
   logic             r_irq_en;
   logic             r_done_flag;
   logic             r_to_flag;
   logic             r_abort_pend;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_timeout;
   logic [CNT_W-1:0] r_frames_done;
   logic [CNT_W-1:0] r_last_cycles;
   logic [CNT_W-1:0] r_cyc;
   logic [KW-1:0]    r_kill_cnt;
   logic [31:0]      r_rdata;

   logic [ADDR_W-3:0] w_widx;
   logic              w_sel_ctrl, w_sel_status, w_sel_num, w_sel_timeout;
   logic              w_go, w_abort, w_done_clr, w_to_clr;
   logic [CNT_W-1:0]  w_num_eff, w_cyc_inc, w_frames_inc;
   logic              w_wd_hit;
   logic              w_unused_addr;

   // Address decode on the word index; byte lanes are ignored.
   assign w_widx        = reg_addr[ADDR_W-1:2];
   assign w_unused_addr = ^reg_addr[1:0];
   assign w_sel_ctrl    = (w_widx == REG_CTRL[ADDR_W-1:2]);
   assign w_sel_status  = (w_widx == REG_STATUS[ADDR_W-1:2]);
   assign w_sel_num     = (w_widx == REG_NUM_FRAMES[ADDR_W-1:2]);
   assign w_sel_timeout = (w_widx == REG_TIMEOUT[ADDR_W-1:2]);

   assign w_go       = reg_wr && w_sel_ctrl && reg_wdata[CTRL_GO];
   // An abort that collides with done in WAIT is held pending and acted on
   // in RELEASE, so it is never lost.
   assign w_abort    = (reg_wr && w_sel_ctrl && reg_wdata[CTRL_ABORT]) || r_abort_pend;
   assign w_done_clr = reg_wr && w_sel_status && reg_wdata[ST_DONE];
   assign w_to_clr   = reg_wr && w_sel_status && reg_wdata[ST_TO];

   assign w_num_eff    = (r_num == '0) ? CNT_W'(1) : r_num;
   assign w_cyc_inc    = (&r_cyc) ? r_cyc : r_cyc + CNT_W'(1);
   assign w_frames_inc = r_frames_done + CNT_W'(1);
   assign w_wd_hit     = (r_timeout != '0) && (w_cyc_inc == r_timeout);

   // Register file, flags and sequencing FSM. Flag clears are applied first
   // so that a same-cycle set from the FSM overrides them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_start       <= 1'b0;
         r_conv_rst_n  <= 1'b1;
         r_bank        <= 1'b0;
         r_irq_en      <= 1'b0;
         r_done_flag   <= 1'b0;
         r_to_flag     <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_num         <= '0;
         r_timeout     <= '0;
         r_frames_done <= '0;
         r_last_cycles <= '0;
         r_cyc         <= '0;
         r_kill_cnt    <= '0;
      end else begin
         if (reg_wr && w_sel_ctrl)    r_irq_en  <= reg_wdata[CTRL_IRQ_EN];
         if (reg_wr && w_sel_num)     r_num     <= CNT_W'(reg_wdata);
         if (reg_wr && w_sel_timeout) r_timeout <= CNT_W'(reg_wdata);
         if (w_done_clr) r_done_flag <= 1'b0;
         if (w_to_clr)   r_to_flag   <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_abort_pend <= 1'b0;
               if (w_go) begin
                  r_state       <= S_LAUNCH;
                  r_frames_done <= '0;
                  r_bank        <= 1'b0;
                  r_done_flag   <= 1'b0;
               end
            end

            S_LAUNCH: begin
               if (w_abort) begin
                  r_state      <= S_KILL;
                  r_start      <= 1'b0;
                  r_conv_rst_n <= 1'b0;
                  r_kill_cnt   <= '0;
                  r_abort_pend <= 1'b0;
               end else begin
                  r_start <= 1'b1;
                  r_cyc   <= '0;
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (conv_done) begin
                  r_start       <= 1'b0;
                  r_last_cycles <= w_cyc_inc;
                  r_abort_pend  <= w_abort;
                  r_state       <= S_RELEASE;
               end else if (w_abort || w_wd_hit) begin
                  r_state      <= S_KILL;
                  r_start      <= 1'b0;
                  r_conv_rst_n <= 1'b0;
                  r_kill_cnt   <= '0;
                  r_abort_pend <= 1'b0;
                  if (w_wd_hit) r_to_flag <= 1'b1;
               end else begin
                  r_cyc <= w_cyc_inc;
               end
            end

            S_RELEASE: begin
               if (w_abort) begin
                  r_state      <= S_KILL;
                  r_conv_rst_n <= 1'b0;
                  r_kill_cnt   <= '0;
                  r_abort_pend <= 1'b0;
               end else if (!conv_done) begin
                  r_state <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (w_abort) begin
                  r_state      <= S_KILL;
                  r_conv_rst_n <= 1'b0;
                  r_kill_cnt   <= '0;
                  r_abort_pend <= 1'b0;
               end else begin
                  r_frames_done <= w_frames_inc;
                  r_bank        <= ~r_bank;
                  // >= guards against NUM_FRAMES being lowered mid-job.
                  if (w_frames_inc >= w_num_eff) begin
                     r_state     <= S_IDLE;
                     r_done_flag <= 1'b1;
                  end else begin
                     r_state <= S_LAUNCH;
                  end
               end
            end

            S_KILL: begin
               r_abort_pend <= 1'b0;
               r_kill_cnt   <= r_kill_cnt + KW'(1);
               if (r_kill_cnt == KILL_LAST) begin
                  r_conv_rst_n <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_start      <= 1'b0;
               r_conv_rst_n <= 1'b1;
            end
         endcase
      end
   end

   // Read port samples the pre-write register values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (reg_rd) begin
         r_rdata <= '0;
         case (w_widx)
            REG_CTRL[ADDR_W-1:2]:        r_rdata[CTRL_IRQ_EN] <= r_irq_en;
            REG_STATUS[ADDR_W-1:2]:      r_rdata[3:0] <= {r_bank, r_to_flag, r_done_flag,
                                                          (r_state != S_IDLE)};
            REG_NUM_FRAMES[ADDR_W-1:2]:  r_rdata <= 32'(r_num);
            REG_FRAMES_DONE[ADDR_W-1:2]: r_rdata <= 32'(r_frames_done);
            REG_LAST_CYCLES[ADDR_W-1:2]: r_rdata <= 32'(r_last_cycles);
            REG_TIMEOUT[ADDR_W-1:2]:     r_rdata <= 32'(r_timeout);
            default:                     r_rdata <= '0;
         endcase
      end
   end

   assign reg_rdata  = r_rdata;
   assign conv_start = r_start;
   assign conv_rst_n = r_conv_rst_n;
   assign bank_sel   = r_bank;
   assign busy       = (r_state != S_IDLE);
   assign irq        = (r_done_flag | r_to_flag) & r_irq_en;

endmodule

// File: tb/tb_conv_job_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_job_sched
//   Directed bench for conv_job_sched with a stub convolution core whose
//   done level is asserted on the N-th cycle that start is high and drops
//   as soon as start drops.
// ---------------------------------------------------------------------------
module tb_conv_job_sched;

   localparam logic [4:0] A_CTRL   = 5'h00;
   localparam logic [4:0] A_STATUS = 5'h04;
   localparam logic [4:0] A_NUM    = 5'h08;
   localparam logic [4:0] A_FDONE  = 5'h0C;
   localparam logic [4:0] A_LAST   = 5'h10;
   localparam logic [4:0] A_TMO    = 5'h14;
   localparam logic [4:0] A_UNMAP  = 5'h18;

   logic        clk, rst_n;
   logic        reg_wr, reg_rd;
   logic [4:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        conv_start, conv_done, conv_rst_n, bank_sel, busy, irq;

   int checks   = 0;
   int failures = 0;

   conv_job_sched #(.ADDR_W(5), .CNT_W(32), .RST_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .conv_start (conv_start),
      .conv_done  (conv_done),
      .conv_rst_n (conv_rst_n),
      .bank_sel   (bank_sel),
      .busy       (busy),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub core
   int stub_n = 20;
   int stub_cnt;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) stub_cnt <= 0;
      else        stub_cnt <= conv_start ? stub_cnt + 1 : 0;
   assign conv_done = conv_start && (stub_cnt >= stub_n - 1);

   // Monitor, sampled 1 time unit after each rising edge
   int   mon_starts = 0, mon_hi = 0, mon_rstlo = 0;
   logic mon_prev = 1'b0;
   logic mon_bank [64];
   always begin
      @(posedge clk);
      #1;
      if (conv_start && !mon_prev) begin
         mon_starts = mon_starts + 1;
         mon_bank[mon_starts % 64] = bank_sel;
      end
      if (conv_start)  mon_hi    = mon_hi + 1;
      if (!conv_rst_n) mon_rstlo = mon_rstlo + 1;
      mon_prev = conv_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // All bus tasks are entered at a falling edge and return at one.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      reg_rd = 1'b1; reg_addr = a;
      @(negedge clk);
      reg_rd = 1'b0;
      chk(tag, reg_rdata, exp);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_starts(input string tag, input int target, input int budget);
      int n = 0;
      while (mon_starts < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(mon_starts), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int b_st, b_hi, b_rl, falls;
      logic prev;

      rst_n = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_start", 32'(conv_start), 32'd0);
      chk("rst_convrst", 32'(conv_rst_n), 32'd1);
      chk("rst_bank", 32'(bank_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("rst_status", A_STATUS, 32'h0);
      rd_chk("rst_num", A_NUM, 32'h0);
      rd_chk("rst_tmo", A_TMO, 32'h0);
      rd_chk("unmapped", A_UNMAP, 32'h0);

      // Same-cycle write and read of NUM_FRAMES returns the old value
      reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = A_NUM; reg_wdata = 32'd3;
      @(negedge clk);
      reg_wr = 1'b0; reg_rd = 1'b0;
      chk("wr_rd_old", reg_rdata, 32'h0);
      rd_chk("num_new", A_NUM, 32'd3);

      // 1: three frames of 20 cycles
      stub_n = 20; b_st = mon_starts; b_hi = mon_hi;
      wr(A_CTRL, 32'h5);
      wait_idle("t1_idle", 400);
      chk("t1_starts", 32'(mon_starts - b_st), 32'd3);
      chk("t1_hi", 32'(mon_hi - b_hi), 32'd60);
      chk("t1_bank0", 32'(mon_bank[(b_st + 1) % 64]), 32'd0);
      chk("t1_bank1", 32'(mon_bank[(b_st + 2) % 64]), 32'd1);
      chk("t1_bank2", 32'(mon_bank[(b_st + 3) % 64]), 32'd0);
      rd_chk("t1_fdone", A_FDONE, 32'd3);
      rd_chk("t1_last", A_LAST, 32'd20);
      rd_chk("t1_status", A_STATUS, 32'hA);
      chk("t1_irq_on", 32'(irq), 32'd1);
      wr(A_CTRL, 32'h0);
      chk("t1_irq_off", 32'(irq), 32'd0);

      // 2: watchdog
      wr(A_STATUS, 32'h6);
      wr(A_TMO, 32'd10);
      wr(A_NUM, 32'd1);
      stub_n = 50; b_hi = mon_hi; b_rl = mon_rstlo;
      wr(A_CTRL, 32'h1);
      wait_idle("t2_idle", 200);
      @(negedge clk);
      chk("t2_hi", 32'(mon_hi - b_hi), 32'd10);
      chk("t2_rstlo", 32'(mon_rstlo - b_rl), 32'd2);
      rd_chk("t2_status", A_STATUS, 32'h4);
      rd_chk("t2_fdone", A_FDONE, 32'd0);
      rd_chk("t2_last_kept", A_LAST, 32'd20);
      wr(A_STATUS, 32'h4);
      wr(A_TMO, 32'd0);
      rd_chk("t2_w1c", A_STATUS, 32'h0);

      // 3: abort during frame 2 of 4
      wr(A_NUM, 32'd4);
      stub_n = 20; b_st = mon_starts; b_rl = mon_rstlo;
      wr(A_CTRL, 32'h1);
      wait_starts("t3_frame2", b_st + 2, 200);
      repeat (5) @(negedge clk);
      chk("t3_pre_start", 32'(conv_start), 32'd1);
      wr(A_CTRL, 32'h2);
      chk("t3_start_drop", 32'(conv_start), 32'd0);
      wait_idle("t3_idle", 50);
      @(negedge clk);
      chk("t3_rstlo", 32'(mon_rstlo - b_rl), 32'd2);
      chk("t3_starts", 32'(mon_starts - b_st), 32'd2);
      rd_chk("t3_fdone", A_FDONE, 32'd1);
      rd_chk("t3_status", A_STATUS, 32'h8);

      // 4: W1C of done_flag landing on the final NEXT cycle
      wr(A_NUM, 32'd3);
      stub_n = 5;
      wr(A_CTRL, 32'h5);
      falls = 0; prev = conv_start;
      for (int i = 0; i < 200 && falls < 3; i++) begin
         @(negedge clk);
         if (prev && !conv_start) falls++;
         prev = conv_start;
      end
      chk("t4_falls", 32'(falls), 32'd3);
      @(negedge clk);            // RELEASE -> NEXT edge follows
      wr(A_STATUS, 32'h6);       // sampled on the NEXT edge
      chk("t4_busy", 32'(busy), 32'd0);
      rd_chk("t4_status_set_wins", A_STATUS, 32'hA);
      chk("t4_irq", 32'(irq), 32'd1);
      rd_chk("t4_fdone", A_FDONE, 32'd3);
      wr(A_STATUS, 32'h2);
      rd_chk("t4_status_clr", A_STATUS, 32'h8);
      chk("t4_irq_clr", 32'(irq), 32'd0);

      // 5: NUM_FRAMES=0 runs one frame; go while busy ignored
      wr(A_NUM, 32'd0);
      stub_n = 8; b_st = mon_starts;
      wr(A_CTRL, 32'h1);
      chk("t5_lat1", 32'(conv_start), 32'd0);
      @(negedge clk);
      chk("t5_lat2", 32'(conv_start), 32'd1);
      repeat (3) @(negedge clk);
      wr(A_CTRL, 32'h1);
      wait_idle("t5_idle", 100);
      repeat (20) @(negedge clk);
      chk("t5_still_idle", 32'(busy), 32'd0);
      chk("t5_starts", 32'(mon_starts - b_st), 32'd1);
      rd_chk("t5_fdone", A_FDONE, 32'd1);
      rd_chk("t5_last", A_LAST, 32'd8);

      // 6: async reset mid-job
      wr(A_NUM, 32'd2);
      stub_n = 30; b_st = mon_starts;
      wr(A_CTRL, 32'h5);
      wait_starts("t6_frame2", b_st + 2, 200);
      repeat (4) @(negedge clk);
      chk("t6_pre_bank", 32'(bank_sel), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_start", 32'(conv_start), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_convrst", 32'(conv_rst_n), 32'd1);
      chk("t6_bank", 32'(bank_sel), 32'd0);
      chk("t6_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("t6_num", A_NUM, 32'd0);
      rd_chk("t6_status", A_STATUS, 32'h0);
      stub_n = 8;
      wr(A_CTRL, 32'h1);
      wait_idle("t6_idle", 100);
      rd_chk("t6_fdone", A_FDONE, 32'd1);
      rd_chk("t6_last", A_LAST, 32'd8);
      rd_chk("t6_status_end", A_STATUS, 32'hA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
